i2c_slave_regs: RTL
===================

I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'b0010000, which is the 7-bit address the block responds to.
REQ-002 SHALL have parameter NUM_REGS, default 8, which is the number of 8-bit registers (a power of two, 2..16).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic runs on its rising edge.
REQ-004 SHALL have port resetN, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port scl_in, input, 1 bit: sampled bus SCL (the block never drives SCL).
REQ-006 SHALL have port sda_in, input, 1 bit: sampled bus SDA.
REQ-007 SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low; 0 releases it (open-drain, external pullup).
REQ-008 SHALL have ports reg_rd_addr (input, log2(NUM_REGS) bits) and reg_rd_data (output, 8 bits): combinational host read of the register file.
REQ-009 SHALL have port wr_strobe, output, 1 bit: a 1-clk pulse on each register write from I2C.
REQ-010 SHALL have port busy, output, 1 bit: high from an address match until STOP, or until the next START.

Function
REQ-011 SHALL pass scl_in and sda_in through a 2-flop synchronizer; all detection uses the synchronized values and their previous-cycle copies.
REQ-012 SHALL detect START as SDA falling while SCL high, and STOP as SDA rising while SCL high; clk SHALL be at least 10x the SCL rate.
REQ-013 SHALL sample SDA data bits on the synchronized SCL rising edge, MSB first.
REQ-014 SHALL change sda_oe only on the clk cycle after a synchronized SCL falling edge.
REQ-015 SHALL have these FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-016 SHALL go from any state to ADDR on START (this covers repeated START), clearing the bit counter and releasing SDA.
REQ-017 SHALL go from any state to IDLE on STOP, releasing SDA and clearing busy.
REQ-018 In ADDR, after 8 bits: if bits[7:1] equal SLAVE_ADDR, SHALL go to ADDR_ACK, drive ACK (sda_oe=1) for the 9th clock and set busy; otherwise SHALL go to IGNORE with SDA released (NACK).
REQ-019 After ADDR_ACK, if R/W=0 SHALL go to PTR; if R/W=1 SHALL go to RDATA and load the shift register with regs[ptr].
REQ-020 In PTR, the received byte modulo NUM_REGS SHALL be loaded into ptr, then ACK SHALL be given, then the FSM SHALL go to WDATA.
REQ-021 In WDATA, each received byte SHALL be written to regs[ptr], wr_strobe pulsed on the 8th SCL rise, ptr incremented, and ACK given; it SHALL repeat until STOP or START.
REQ-022 In RDATA, SHALL drive sda_oe = ~bit for 8 bits, then release SDA and sample the master's ACK in RDATA_ACK.
REQ-023 In RDATA_ACK, master ACK (0) SHALL increment ptr, reload from regs[ptr] and return to RDATA; NACK (1) SHALL go to IGNORE.
REQ-024 ptr SHALL wrap from NUM_REGS-1 to 0 on both write and read.
REQ-025 ptr SHALL persist across transactions, so a write of only a pointer followed by a repeated-START read returns regs[ptr].
REQ-026 IGNORE SHALL keep SDA released and leave only on START or STOP.
REQ-027 General call address 7'b0000000 SHALL be NACKed unless it equals SLAVE_ADDR.
REQ-028 If START and STOP conditions are detected mid-byte, the partial byte SHALL be discarded with no register write.
REQ-029 If wr_strobe write and host read of the same register occur in the same cycle, reg_rd_data SHALL show the old value; the new value SHALL appear the next cycle.

Reset
REQ-030 While resetN=0, SHALL hold: sda_oe=0, wr_strobe=0, busy=0, state=IDLE, ptr=0, all regs=8'h00, and synchronizer flops=1.
REQ-031 resetN assertion mid-transfer SHALL release SDA immediately, without waiting for clk.
REQ-032 After reset release, SHALL ignore bus activity until the first START.

Verification
REQ-033 Write 0x20, ptr 0x02, data 0xA5, 0x5A, STOP -> each byte ACKed, regs[2]=0xA5, regs[3]=0x5A, two wr_strobe pulses, busy low after STOP.
REQ-034 Write 0x20, ptr 0x07, data 0x11, 0x22 -> regs[7]=0x11, regs[0]=0x22 (wrap).
REQ-035 Write 0x20, ptr 0x02, repeated START, 0x21, read 2 bytes (ACK, then NACK) -> SDA carries 0xA5 then 0x5A; SDA released after NACK; ptr=4.
REQ-036 Address 0x22 (addr 0x11), 3 bytes -> 9th bit high (NACK), sda_oe never 1, busy stays 0, regs unchanged.
REQ-037 resetN pulled low during 4th bit of a data byte -> sda_oe=0 at once, regs all 0x00, next full write transaction succeeds.
REQ-038 STOP injected after 5 bits of a data byte -> no write, no wr_strobe, state IDLE.

Source files
------------

// File: rtl/i2c_slave_regs.sv
// I2C target exposing a byte-wide register file behind an auto-incrementing pointer.
// Only the I2C side writes the registers; the host reads them combinationally.
module i2c_slave_regs #(
  parameter logic [6:0]  SLAVE_ADDR = 7'b0010000,
  parameter int unsigned NUM_REGS   = 8
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        scl_in,
  input  logic                        sda_in,
  output logic                        sda_oe,
  input  logic [$clog2(NUM_REGS)-1:0] reg_rd_addr,
  output logic [7:0]                  reg_rd_data,
  output logic                        wr_strobe,
  output logic                        busy
);
  localparam int unsigned PW = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
    StWdata, StWdataAck, StRdata, StRdataAck, StIgnore
  } state_e;

  state_e        state_q, state_d;
  logic          scl_meta_q, scl_sync_q, scl_prev_q;
  logic          sda_meta_q, sda_sync_q, sda_prev_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          ack_rise_q;
  logic [PW-1:0] ptr_q;
  logic [7:0]    regs_q [NUM_REGS];
  logic          sda_oe_q, sda_oe_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic          busy_q, busy_d;

  logic       scl_rise, scl_fall, start_det, stop_det, byte_done, addr_match, rw_read;
  logic [7:0] byte_in;

  assign scl_rise   = scl_sync_q & ~scl_prev_q;
  assign scl_fall   = ~scl_sync_q & scl_prev_q;
  assign start_det  = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
  assign stop_det   = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
  assign byte_in    = {shift_q[6:0], sda_sync_q};
  assign byte_done  = scl_rise & (bit_cnt_q == 3'd7);
  assign addr_match = (byte_in[7:1] == SLAVE_ADDR);
  // After the address byte, bit 0 of the shift register is the R/W flag.
  assign rw_read    = shift_q[0];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Ack states span two SCL falls: the first drives ACK, the second (after the 9th rise) exits.
  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = StAddr;
    end else if (stop_det) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StAddr:     if (byte_done) state_d = addr_match ? StAddrAck : StIgnore;
        StAddrAck:  if (scl_fall && ack_rise_q) state_d = rw_read ? StRdata : StPtr;
        StPtr:      if (byte_done) state_d = StPtrAck;
        StPtrAck:   if (scl_fall && ack_rise_q) state_d = StWdata;
        StWdata:    if (byte_done) state_d = StWdataAck;
        StWdataAck: if (scl_fall && ack_rise_q) state_d = StWdata;
        StRdata:    if (scl_rise && bit_cnt_q == 3'd7) state_d = StRdataAck;
        StRdataAck: if (scl_rise) state_d = sda_sync_q ? StIgnore : StRdata;
        default:    state_d = state_q;
      endcase
    end
  end

  always_comb begin
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    if (start_det || stop_det) begin
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        StAddr:  if (byte_done && addr_match) busy_d = 1'b1;
        StAddrAck, StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            if (!ack_rise_q) begin
              sda_oe_d = 1'b1;
            end else if (state_q == StAddrAck && rw_read) begin
              sda_oe_d = ~regs_q[ptr_q][7];
            end else begin
              sda_oe_d = 1'b0;
            end
          end
        end
        StWdata:    if (byte_done) wr_strobe_d = 1'b1;
        StRdata:    if (scl_fall) sda_oe_d = ~shift_q[7];
        StRdataAck: if (scl_fall) sda_oe_d = 1'b0;
        default:    sda_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      scl_meta_q  <= 1'b1;
      scl_sync_q  <= 1'b1;
      scl_prev_q  <= 1'b1;
      sda_meta_q  <= 1'b1;
      sda_sync_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ack_rise_q  <= 1'b0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      scl_meta_q  <= scl_in;
      scl_sync_q  <= scl_meta_q;
      scl_prev_q  <= scl_sync_q;
      sda_meta_q  <= sda_in;
      sda_sync_q  <= sda_meta_q;
      sda_prev_q  <= sda_sync_q;
      sda_oe_q    <= sda_oe_d;
      wr_strobe_q <= wr_strobe_d;
      busy_q      <= busy_d;
      if (start_det || stop_det) begin
        bit_cnt_q  <= '0;
        ack_rise_q <= 1'b0;
      end else begin
        case (state_q)
          StAddr, StPtr, StWdata: begin
            if (scl_rise) begin
              shift_q   <= byte_in;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7 && state_q == StPtr) ptr_q <= byte_in[PW-1:0];
              if (bit_cnt_q == 3'd7 && state_q == StWdata) begin
                regs_q[ptr_q] <= byte_in;
                ptr_q         <= ptr_q + PW'(1);
              end
            end
          end
          StAddrAck, StPtrAck, StWdataAck: begin
            if (scl_rise) ack_rise_q <= 1'b1;
            if (scl_fall && ack_rise_q) begin
              ack_rise_q <= 1'b0;
              if (state_q == StAddrAck && rw_read) shift_q <= regs_q[ptr_q];
            end
          end
          StRdata: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              // Pointer advances after every byte sent, whether or not the master ACKs it.
              if (bit_cnt_q == 3'd7) ptr_q <= ptr_q + PW'(1);
            end
          end
          StRdataAck: if (scl_rise && !sda_sync_q) shift_q <= regs_q[ptr_q];
          default: ;
        endcase
      end
    end
  end

  assign sda_oe      = sda_oe_q;
  assign wr_strobe   = wr_strobe_q;
  assign busy        = busy_q;
  assign reg_rd_data = regs_q[reg_rd_addr];

endmodule
